// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge
//   Sits between the core's data-memory port and the data RAM. Word addresses
//   whose upper 28 bits match MMIO_BASE go to a 16-register MMIO window. All
//   other addresses pass straight through to the RAM.
//   The window holds a UART transmitter (byte FIFO feeding an 8N1 serializer)
//   and a free-running 32-bit timer with a compare register and a sticky IRQ.
//   Loads from either target return one edge after the address, like the RAM.
//
// Ports
//   clock      master clock; all state changes on posedge
//   reset      asynchronous, active-low reset
//   cpu_addr   word address from the core
//   cpu_data   store data from the core
//   cpu_wren   store strobe from the core
//   cpu_q      load data back to the core (MMIO or RAM, one edge later)
//   ram_addr   RAM word address (low RAM_AW bits of cpu_addr)
//   ram_data   RAM write data (cpu_data)
//   ram_wren   RAM write enable, suppressed for MMIO addresses
//   ram_q      RAM read data (registered inside the RAM)
//   uart_tx    serial output, idle high
//   timer_irq  sticky timer compare flag
module dmem_mmio_bridge #(
    parameter logic [31:0] MMIO_BASE    = 32'h0000_F000,
    parameter int          RAM_AW       = 12,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_data,
    input  logic              cpu_wren,
    output logic [31:0]       cpu_q,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    input  logic [31:0]       ram_q,
    output logic              uart_tx,
    output logic              timer_irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    localparam logic [3:0] OFF_TXDATA  = 4'd0;
    localparam logic [3:0] OFF_STATUS  = 4'd1;
    localparam logic [3:0] OFF_TIMER   = 4'd2;
    localparam logic [3:0] OFF_TIMECMP = 4'd3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // ---------------- address decode and RAM pass-through ----------------
    logic       sel_mmio;
    logic [3:0] off;
    logic       mmio_wr;
    logic       wr_txdata, wr_status, wr_timer, wr_timecmp;

    assign sel_mmio   = (cpu_addr[31:4] == MMIO_BASE[31:4]);
    assign off        = cpu_addr[3:0];
    assign mmio_wr    = cpu_wren & sel_mmio;
    assign wr_txdata  = mmio_wr & (off == OFF_TXDATA);
    assign wr_status  = mmio_wr & (off == OFF_STATUS);
    assign wr_timer   = mmio_wr & (off == OFF_TIMER);
    assign wr_timecmp = mmio_wr & (off == OFF_TIMECMP);

    assign ram_addr = cpu_addr[RAM_AW-1:0];
    assign ram_data = cpu_data;
    assign ram_wren = cpu_wren & ~sel_mmio;

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop, ovf;
    tx_state_t     state;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    // The serializer only pops from IDLE, so a push into an empty FIFO is
    // popped on the following edge (no bypass).
    assign pop   = (state == IDLE) && !empty;
    // A full FIFO still accepts a byte on the edge that frees a slot.
    assign push  = wr_txdata && (!full || pop);

    // NOTE: the byte storage is deliberately left out of reset; only the
    // pointers and count define what is valid, so clearing the array buys
    // nothing and costs a reset path on every storage bit.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= cpu_data[7:0];
    end

    // NOTE: clocked state is always assigned with <=, so every register in a
    // block samples the pre-edge values no matter the statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (wr_txdata && !push) ovf <= 1'b1;
            else if (wr_status)     ovf <= 1'b0;
        end
    end

    // ---------------- 8N1 serializer ----------------
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          baud_done;

    assign baud_done = (baud == CW'(CLKS_PER_BIT - 1));

    // uart_tx is registered and loaded together with each state change, so
    // the line level always matches the state it belongs to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift   <= fifo_mem[rd_ptr];
                        baud    <= '0;
                        uart_tx <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        uart_tx <= shift[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- timer and compare IRQ ----------------
    logic [31:0] timer, timecmp;
    logic        irq;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            timecmp <= '0;
            irq     <= 1'b0;
        end else begin
            timer <= wr_timer ? cpu_data : timer + 32'd1;
            if (wr_timecmp) timecmp <= cpu_data;
            // A compare write clears the flag even if a match lands on the same edge.
            if (wr_timecmp)             irq <= 1'b0;
            else if (timer == timecmp)  irq <= 1'b1;
        end
    end

    assign timer_irq = irq;

    // ---------------- read path ----------------
    logic [31:0] rdata, mmio_q;
    logic        sel_q, busy;

    assign busy = (state != IDLE);

    // NOTE: rdata gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rdata = '0;
        if (sel_mmio) begin
            case (off)
                OFF_STATUS:  rdata = {16'b0, 8'(count), 3'b0, irq, ovf, busy, full, empty};
                OFF_TIMER:   rdata = timer;
                OFF_TIMECMP: rdata = timecmp;
                default:     rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_q  <= 1'b0;
            mmio_q <= '0;
        end else begin
            sel_q  <= sel_mmio;
            mmio_q <= rdata;
        end
    end

    assign cpu_q = sel_q ? mmio_q : ram_q;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// tb_dmem_mmio_bridge
//   Self-checking bench for dmem_mmio_bridge with a short bit period and a
//   4-entry FIFO. The bench plays the data RAM, decodes the serial line with
//   an independent receiver, and keeps a reference model of RAM contents and
//   the timer/compare/IRQ registers for a randomized access phase.
module tb_dmem_mmio_bridge;

    localparam logic [31:0] MMIO_BASE  = 32'h0000_F000;
    localparam int          RAM_AW     = 12;
    localparam int          FIFO_DEPTH = 4;
    localparam int          CPB        = 4;

    localparam logic [31:0] A_TXDATA  = MMIO_BASE;
    localparam logic [31:0] A_STATUS  = MMIO_BASE + 32'd1;
    localparam logic [31:0] A_TIMER   = MMIO_BASE + 32'd2;
    localparam logic [31:0] A_TIMECMP = MMIO_BASE + 32'd3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       cpu_addr = '0;
    logic [31:0]       cpu_data = '0;
    logic              cpu_wren = 1'b0;
    logic [31:0]       cpu_q;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic [31:0]       ram_q;
    logic              uart_tx;
    logic              timer_irq;

    always #5 clock = ~clock;

    dmem_mmio_bridge #(
        .MMIO_BASE   (MMIO_BASE),
        .RAM_AW      (RAM_AW),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_wren (cpu_wren),
        .cpu_q    (cpu_q),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q),
        .uart_tx  (uart_tx),
        .timer_irq(timer_irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Data RAM played by the bench: synchronous write and registered read.
    logic [31:0] ram_dev [1<<RAM_AW];
    always @(posedge clock) begin
        if (ram_wren) ram_dev[ram_addr] <= ram_data;
        ram_q <= ram_dev[ram_addr];
    end

    // Edge counter used by the timer model.
    int unsigned cyc = 0;
    always @(posedge clock) cyc++;

    // Serial receiver: finds the start bit and samples each bit mid-period.
    logic [7:0] rx_q[$];
    bit         rx_en = 1'b0;
    always begin : uart_rx
        logic [7:0] b;
        @(negedge clock);
        if (reset && rx_en && uart_tx === 1'b0) begin
            repeat (CPB/2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clock);
                b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clock);
            if (rx_en) begin
                check("rx_stop_bit", uart_tx, 1'b1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1);
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_wren = 1'b1;
        @(posedge clock); #1;
        cpu_wren = 1'b0;
        cpu_data = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] q);
        cpu_addr = a;
        cpu_wren = 1'b0;
        @(posedge clock); #1;
        q = cpu_q;
    endtask

    task automatic idle(input int n);
        cpu_wren = 1'b0;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    typedef struct {
        logic [31:0]       addr;
        logic              wren;
        logic              exp_wren;
        logic [RAM_AW-1:0] exp_ram_addr;
    } dec_vec_t;

    initial begin
        dec_vec_t    dec_tab [8];
        logic [31:0] q, d, a, pre_t, m_cmp, pre_cmp, ld_val;
        logic [31:0] ref_mem [16];
        logic [7:0]  s4 [6];
        logic [9:0]  frame;
        int unsigned ld_edge;
        bit          m_irq, pre_irq;
        int          lows, op;

        dec_tab[0] = '{32'h0000_0005, 1'b1, 1'b1, 12'h005};
        dec_tab[1] = '{32'h0000_EFFF, 1'b1, 1'b1, 12'hFFF};
        dec_tab[2] = '{32'h0000_F000, 1'b1, 1'b0, 12'h000};
        dec_tab[3] = '{32'h0000_F00F, 1'b1, 1'b0, 12'h00F};
        dec_tab[4] = '{32'h0000_F010, 1'b1, 1'b1, 12'h010};
        dec_tab[5] = '{32'hFFFF_F000, 1'b1, 1'b1, 12'h000};
        dec_tab[6] = '{32'h0001_F003, 1'b1, 1'b1, 12'h003};
        dec_tab[7] = '{32'h0000_1234, 1'b0, 1'b0, 12'h234};

        s4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < (1 << RAM_AW); i++) ram_dev[i] = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        // ---- reset state ----
        repeat (3) @(posedge clock);
        #1;
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_timer_irq", timer_irq, 1'b0);
        @(negedge clock) reset = 1'b1;
        bus_read(A_STATUS, q);
        check("status_after_reset", q, 32'h1);
        check("idle_uart_tx", uart_tx, 1'b1);
        bus_write(A_TIMECMP, 32'hFFFF_0000);
        check("irq_cleared_by_cmp_write", timer_irq, 1'b0);

        // ---- address decode table ----
        foreach (dec_tab[i]) begin
            @(negedge clock);
            d = $urandom;
            cpu_addr = dec_tab[i].addr;
            cpu_data = d;
            cpu_wren = dec_tab[i].wren;
            #1;
            check($sformatf("dec%0d_ram_wren", i), ram_wren, dec_tab[i].exp_wren);
            check($sformatf("dec%0d_ram_addr", i), ram_addr, dec_tab[i].exp_ram_addr);
            check($sformatf("dec%0d_ram_data", i), ram_data, d);
            cpu_wren = 1'b0;
        end
        @(posedge clock); #1;

        // ---- RAM pass-through and MMIO isolation ----
        bus_write(32'd5, 32'h123);
        ref_mem[5] = 32'h123;
        bus_read(32'd5, q);
        check("ram_readback", q, 32'h123);
        cpu_addr = A_TIMER;
        cpu_data = 32'd0;
        cpu_wren = 1'b1;
        #1;
        check("mmio_write_no_ram_wren", ram_wren, 1'b0);
        @(posedge clock); #1;
        cpu_wren = 1'b0;
        for (int i = 4; i < 16; i++) begin
            bus_write(MMIO_BASE + 32'(i), $urandom);
            bus_read(MMIO_BASE + 32'(i), q);
            check($sformatf("unused_off%0d", i), q, 32'h0);
        end

        // ---- single frame, bit-by-bit ----
        rx_en = 1'b1;
        bus_write(A_TXDATA, 32'h0000_00A5);
        check("tx_high_on_push_edge", uart_tx, 1'b1);
        frame = {1'b1, 8'hA5, 1'b0};
        cpu_addr = A_STATUS;
        for (int k = 0; k < 10*CPB; k++) begin
            @(posedge clock); #1;
            check($sformatf("frame_clk%0d", k), uart_tx, frame[k/CPB]);
        end
        @(posedge clock); #1;
        check("tx_high_after_frame", uart_tx, 1'b1);
        check("busy_in_last_stop_clk", cpu_q[2], 1'b1);
        @(posedge clock); #1;
        check("status_idle_after_frame", cpu_q, 32'h1);
        check("rx_count_a5", rx_q.size(), 1);
        if (rx_q.size() > 0) check("rx_byte_a5", rx_q[0], 8'hA5);
        rx_q.delete();

        // ---- FIFO overflow ----
        for (int i = 0; i < 6; i++) bus_write(A_TXDATA, {24'h0, s4[i]});
        bus_read(A_STATUS, q);
        check("status_full_ovf", q, 32'h0000_040E);
        bus_write(A_STATUS, 32'hFFFF_FFFF);
        bus_read(A_STATUS, q);
        check("status_ovf_cleared", q, 32'h0000_0406);
        for (int t = 0; t < 600 && rx_q.size() < 5; t++) @(posedge clock);
        #1;
        idle(60);
        check("rx_frames_after_ovf", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check($sformatf("rx_byte%0d", i), rx_q[i], s4[i]);
        bus_read(A_STATUS, q);
        check("status_drained", q, 32'h1);
        rx_q.delete();

        // ---- reset in the middle of a data bit ----
        rx_en = 1'b0;
        bus_write(A_TXDATA, 32'h00);
        bus_write(A_TXDATA, 32'h5A);
        bus_write(A_TXDATA, 32'h3C);
        cpu_addr = A_STATUS;
        repeat (16) @(posedge clock);
        #1;
        check("two_queued_busy", cpu_q, 32'h0000_0204);
        check("data_bit3_low", uart_tx, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("reset_forces_tx_high", uart_tx, 1'b1);
        check("reset_irq_low", timer_irq, 1'b0);
        @(negedge clock);
        @(negedge clock) reset = 1'b1;
        bus_read(A_STATUS, q);
        check("status_after_abort", q, 32'h1);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #1;
            if (uart_tx !== 1'b1) lows++;
        end
        check("no_frame_after_reset", lows, 0);

        // ---- timer compare / IRQ ----
        bus_write(A_TIMER, 32'h1000);
        bus_write(A_TIMECMP, 32'd10);
        check("irq_low_after_cmp", timer_irq, 1'b0);
        bus_write(A_TIMER, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clock); #1;
            check($sformatf("irq_clk%0d", k), timer_irq, (k >= 11));
        end
        bus_write(A_TIMECMP, 32'hFFFF_FFF0);
        check("irq_clear", timer_irq, 1'b0);
        bus_write(A_TIMER, 32'h5000);
        bus_write(A_TIMECMP, 32'd100);
        bus_write(A_TIMER, 32'd99);
        idle(1);
        bus_write(A_TIMECMP, 32'hFFFF_FFF0);
        check("clear_beats_set", timer_irq, 1'b0);
        idle(1);
        check("clear_beats_set_hold", timer_irq, 1'b0);
        bus_write(A_TIMER, 32'hFFFF_FFFF);
        bus_read(A_TIMER, q);
        check("timer_max", q, 32'hFFFF_FFFF);
        bus_read(A_TIMER, q);
        check("timer_wrap", q, 32'h0);

        // ---- randomized accesses against the reference model ----
        m_cmp = 32'hFFFF_FFF0;
        m_irq = 1'b0;
        d = $urandom;
        bus_write(A_TIMER, d);
        ld_val  = d;
        ld_edge = cyc;
        for (int n = 0; n < 300; n++) begin
            pre_t   = ld_val + 32'(cyc - ld_edge);
            pre_irq = m_irq;
            pre_cmp = m_cmp;
            op = $urandom_range(0, 8);
            case (op)
                0: begin
                    a = 32'($urandom_range(0, 15));
                    d = $urandom;
                    bus_write(a, d);
                    ref_mem[a[3:0]] = d;
                end
                1: begin
                    a = 32'($urandom_range(0, 15));
                    bus_read(a, q);
                    check("rand_ram_read", q, ref_mem[a[3:0]]);
                end
                2: begin
                    d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
                    bus_write(A_TIMER, d);
                    ld_val  = d;
                    ld_edge = cyc;
                end
                3: begin
                    d = pre_t + 32'($urandom_range(1, 6));
                    bus_write(A_TIMECMP, d);
                    m_cmp = d;
                end
                4: begin
                    bus_read(A_TIMER, q);
                    check("rand_timer_read", q, pre_t);
                end
                5: begin
                    bus_read(A_TIMECMP, q);
                    check("rand_timecmp_read", q, pre_cmp);
                end
                6: begin
                    bus_read(A_STATUS, q);
                    check("rand_status_read", q, {27'b0, pre_irq, 4'b0001});
                end
                7: bus_write(MMIO_BASE + 32'($urandom_range(4, 15)), $urandom);
                default: begin
                    bus_read(MMIO_BASE + 32'($urandom_range(4, 15)), q);
                    check("rand_unused_read", q, 32'h0);
                end
            endcase
            if (op == 3)              m_irq = 1'b0;
            else if (pre_t == pre_cmp) m_irq = 1'b1;
            check("rand_timer_irq", timer_irq, m_irq);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
